universal_shift_register: RTL and testbench

Parametrised universal shift register: loads, shifts logically or arithmetically, and rotates a WIDTH-bit word by a commanded step count, one bit per enabled clock. A valid/ready command handshake and a one-cycle done pulse let a controller sequence multi-bit shifts without counting cycles itself. It is the general-purpose successor to the team's fixed 8-bit left/right shift register, for datapath and serialiser use.

---
 rtl/usr_pkg.sv | 38 +++
 rtl/usr_shift_step.sv | 47 ++++
 rtl/universal_shift_register.sv | 130 +++++++++++++
 tb/tb_universal_shift_register.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: op codes, FSM states and
// the step-op classifier. Optional rotate support is selected by the
// USR_ROTATE_EN macro; when undefined, ROL/ROR are treated as reserved ops.
package usr_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_LOAD = 3'd0,
      OP_SHL  = 3'd1,
      OP_SHR  = 3'd2,
      OP_SAR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_ROR  = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } usr_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } usr_state_e;

   // True for ops that consume cmd_amount single-bit steps.
   function automatic logic is_step_op(input logic [OP_W-1:0] op);
      logic r;
      r = 1'b0;
      case (usr_op_e'(op))
         OP_SHL, OP_SHR, OP_SAR: r = 1'b1;
`ifdef USR_ROTATE_EN
         OP_ROL, OP_ROR:         r = 1'b1;
`endif
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step unit: computes the word after one shift/rotate
// step and the bit leaving the word. Rotates exist only with USR_ROTATE_EN;
// otherwise ops 4/5 pass the word through like any other non-step op.
module usr_shift_step
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [OP_W-1:0]  i_op,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_serial,
   output logic [WIDTH-1:0] o_word,
   output logic             o_bit
);

   // One step of the selected op; non-step ops leave the word untouched.
   always_comb begin
      o_word = i_word;
      o_bit  = 1'b0;
      case (usr_op_e'(i_op))
         OP_SHL: begin
            o_word = {i_word[WIDTH-2:0], i_serial};
            o_bit  = i_word[WIDTH-1];
         end
         OP_SHR: begin
            o_word = {i_serial, i_word[WIDTH-1:1]};
            o_bit  = i_word[0];
         end
         OP_SAR: begin
            o_word = {i_word[WIDTH-1], i_word[WIDTH-1:1]};
            o_bit  = i_word[0];
         end
`ifdef USR_ROTATE_EN
         OP_ROL: begin
            o_word = {i_word[WIDTH-2:0], i_word[WIDTH-1]};
            o_bit  = i_word[WIDTH-1];
         end
         OP_ROR: begin
            o_word = {i_word[0], i_word[WIDTH-1:1]};
            o_bit  = i_word[0];
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: LOAD / SHL / SHR / SAR (and ROL / ROR when
// USR_ROTATE_EN is defined) by a commanded step count, one step per enabled
// clock, with a valid/ready command handshake and a one-cycle done pulse.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [AMT_W-1:0] cmd_amount,
   input  logic [WIDTH-1:0] datain,
   input  logic             serial_in,
   output logic [WIDTH-1:0] dataout,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   usr_state_e       r_state;
   logic [OP_W-1:0]  r_op;
   logic [AMT_W-1:0] r_count;
   logic [WIDTH-1:0] r_data;
   logic             r_sout;
   logic             r_done;

   usr_state_e       w_state_nxt;
   logic [OP_W-1:0]  w_op_nxt;
   logic [AMT_W-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_data_nxt;
   logic             w_sout_nxt;
   logic             w_done_nxt;

   logic [OP_W-1:0]  w_step_op;
   logic [WIDTH-1:0] w_step_word;
   logic             w_step_bit;

   // In IDLE the first step is taken on the accept edge, so the step unit
   // sees the incoming op; in SHIFT it sees the latched op.
   always_comb begin
      w_step_op = (r_state == ST_IDLE) ? cmd_op : r_op;
   end

   usr_shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_op     (w_step_op),
      .i_word   (r_data),
      .i_serial (serial_in),
      .o_word   (w_step_word),
      .o_bit    (w_step_bit)
   );

   // Next-state logic: command decode in IDLE, step/count-down in SHIFT.
   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_count_nxt = r_count;
      w_data_nxt  = r_data;
      w_sout_nxt  = r_sout;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_op_nxt = cmd_op;
               if (cmd_op == OP_LOAD) begin
                  w_data_nxt = datain;
                  w_done_nxt = 1'b1;
               end else if (is_step_op(cmd_op) && (cmd_amount != '0)) begin
                  w_data_nxt = w_step_word;
                  w_sout_nxt = w_step_bit;
                  if (cmd_amount == AMT_W'(1)) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_SHIFT;
                     w_count_nxt = cmd_amount - AMT_W'(1);
                  end
               end else begin
                  // Zero-step and reserved ops: complete without changes.
                  w_done_nxt = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            w_data_nxt  = w_step_word;
            w_sout_nxt  = w_step_bit;
            w_count_nxt = r_count - AMT_W'(1);
            if (r_count == AMT_W'(1)) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and datapath registers; enable low freezes everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
         r_count <= '0;
         r_data  <= '0;
         r_sout  <= 1'b0;
         r_done  <= 1'b0;
      end else if (enable) begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_count <= w_count_nxt;
         r_data  <= w_data_nxt;
         r_sout  <= w_sout_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Status outputs decoded from registered state.
   always_comb begin
      cmd_ready  = (r_state == ST_IDLE);
      busy       = (r_state == ST_SHIFT);
      dataout    = r_data;
      serial_out = r_sout;
      done       = r_done;
   end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8): hand-written
// corner sequences, a table of command vectors, and a randomized run against
// an arithmetic reference model. Follows USR_ROTATE_EN like the design.
module tb_universal_shift_register;

   localparam int W = 8;
`ifdef USR_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [3:0] cmd_amount = 4'd0;
   logic [7:0] datain = 8'h00;
   logic       serial_in = 1'b0;
   logic [7:0] dataout;
   logic       serial_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int failures = 0;

   universal_shift_register #(
      .WIDTH (W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_amount (cmd_amount),
      .datain     (datain),
      .serial_in  (serial_in),
      .dataout    (dataout),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a command for exactly one edge; serial_in stays as given.
   task automatic issue(input logic [2:0] op, input int amt, input logic [7:0] din, input logic sin);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_amount = amt[3:0];
      datain     = din;
      serial_in  = sin;
      tick();
      cmd_valid  = 1'b0;
      datain     = 8'hEE;
   endtask

   // Reference: one step computed with plain integer arithmetic.
   function automatic void mstep(input int op, input logic sin, inout logic [7:0] d, inout logic so);
      int v;
      v = int'(d);
      case (op)
         1: begin so = v[7]; v = ((v << 1) | int'(sin)) & 255; end
         2: begin so = v[0]; v = (v >> 1) | (int'(sin) << 7); end
         3: begin so = v[0]; v = (v >> 1) | (v & 128); end
         4: begin so = v[7]; v = ((v << 1) | (v >> 7)) & 255; end
         5: begin so = v[0]; v = (v >> 1) | ((v & 1) << 7); end
         default: ;
      endcase
      d = v[7:0];
   endfunction

   function automatic bit multi_op(input int op);
      return (op >= 1 && op <= 3) || (ROT && (op == 4 || op == 5));
   endfunction

   typedef struct {
      logic [2:0] op;
      int         amt;
      logic [7:0] init;
      logic [7:0] din;
      logic       sin;
      logic [7:0] exp_d;
      logic       exp_so;
      int         exp_lat;
   } vec_t;

   vec_t vecs[11];

   // Model state for the randomized section.
   logic [7:0] m_d;
   logic       m_so;
   logic       m_done;
   int         m_rem;
   int         m_op;

   initial begin
      int lat;

      // Vector table: {op, amt, init, cmd datain, serial_in, exp data, exp serial_out, latency}
      vecs[0]  = '{3'd1, 3,  8'h81, 8'hEE, 1'b1, 8'h0F, 1'b0, 3};
      vecs[1]  = '{3'd3, 2,  8'h90, 8'hEE, 1'b1, 8'hE4, 1'b0, 2};
      vecs[2]  = '{3'd2, 8,  8'hFF, 8'hEE, 1'b0, 8'h00, 1'b1, 8};
      vecs[3]  = '{3'd1, 12, 8'h0F, 8'hEE, 1'b1, 8'hFF, 1'b1, 12};
      vecs[4]  = '{3'd2, 0,  8'h5A, 8'hEE, 1'b1, 8'h5A, 1'b1, 1};
      vecs[5]  = '{3'd6, 3,  8'h33, 8'hEE, 1'b1, 8'h33, 1'b1, 1};
      vecs[6]  = '{3'd2, 1,  8'h02, 8'hEE, 1'b1, 8'h81, 1'b0, 1};
      if (ROT) begin
         vecs[7] = '{3'd5, 9, 8'h01, 8'hEE, 1'b0, 8'h80, 1'b1, 9};
         vecs[8] = '{3'd4, 1, 8'h80, 8'hEE, 1'b0, 8'h01, 1'b1, 1};
      end else begin
         vecs[7] = '{3'd5, 9, 8'h01, 8'hEE, 1'b0, 8'h01, 1'b0, 1};
         vecs[8] = '{3'd4, 1, 8'h80, 8'hEE, 1'b0, 8'h80, 1'b0, 1};
      end
      vecs[9]  = '{3'd3, 3,  8'h7F, 8'hEE, 1'b1, 8'h0F, 1'b1, 3};
      vecs[10] = '{3'd0, 5,  8'h00, 8'hC3, 1'b0, 8'hC3, 1'b1, 1};

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_data", dataout, 8'h00);
      chk("rst_sout", serial_out, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);

      // LOAD completes in one cycle
      issue(3'd0, 0, 8'hA5, 1'b0);
      chk("load_data", dataout, 8'hA5);
      chk("load_done", done, 1'b1);
      chk("load_sout", serial_out, 1'b0);
      tick();
      chk("load_done_clr", done, 1'b0);

      // SHL 0x81 by 3, per-step trace
      issue(3'd0, 0, 8'h81, 1'b0);
      issue(3'd1, 3, 8'hEE, 1'b1);
      chk("shl_s1", dataout, 8'h03);
      chk("shl_s1_busy", busy, 1'b1);
      chk("shl_s1_ready", cmd_ready, 1'b0);
      chk("shl_s1_done", done, 1'b0);
      tick();
      chk("shl_s2", dataout, 8'h07);
      chk("shl_s2_busy", busy, 1'b1);
      chk("shl_s2_done", done, 1'b0);
      tick();
      chk("shl_s3", dataout, 8'h0F);
      chk("shl_s3_busy", busy, 1'b0);
      chk("shl_s3_done", done, 1'b1);
      chk("shl_s3_ready", cmd_ready, 1'b1);
      chk("shl_sout", serial_out, 1'b0);
      tick();
      chk("shl_done_once", done, 1'b0);

      // Reset in the middle of SHR 0xFF by 5
      issue(3'd0, 0, 8'hFF, 1'b0);
      issue(3'd2, 5, 8'hEE, 1'b0);
      chk("abort_s1", dataout, 8'h7F);
      tick();
      chk("abort_s2", dataout, 8'h3F);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_data", dataout, 8'h00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_ready", cmd_ready, 1'b1);
      chk("abort_done", done, 1'b0);
      chk("abort_sout", serial_out, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_done", done, 1'b0);
      end

      // Stall: SHL 0x01 by 4 with enable low for 3 cycles; a LOAD offered
      // while busy must be ignored.
      issue(3'd0, 0, 8'h01, 1'b0);
      issue(3'd1, 4, 8'hEE, 1'b0);
      lat = 1;
      chk("stall_s1", dataout, 8'h02);
      enable    = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      datain    = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         lat++;
         chk("stall_frozen", dataout, 8'h02);
         chk("stall_busy", busy, 1'b1);
      end
      enable = 1'b1;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      cmd_valid = 1'b0;
      chk("stall_done_seen", done, 1'b1);
      chk("stall_data", dataout, 8'h10);
      chk("stall_latency", lat, 7);

      // N=0
      tick();
      issue(3'd0, 0, 8'h3C, 1'b0);
      issue(3'd1, 0, 8'hEE, 1'b1);
      chk("n0_data", dataout, 8'h3C);
      chk("n0_done", done, 1'b1);
      chk("n0_busy", busy, 1'b0);

      // Table-driven vectors
      for (int v = 0; v < 11; v++) begin
         issue(3'd0, 0, vecs[v].init, 1'b0);
         issue(vecs[v].op, vecs[v].amt, vecs[v].din, vecs[v].sin);
         lat = 1;
         while (!done && lat < 40) begin
            tick();
            lat++;
         end
         chk($sformatf("vec%0d_done", v), done, 1'b1);
         chk($sformatf("vec%0d_data", v), dataout, vecs[v].exp_d);
         chk($sformatf("vec%0d_sout", v), serial_out, vecs[v].exp_so);
         chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      end

      // Randomized run against the reference model
      m_d = 8'h00; m_so = 1'b0; m_done = 1'b0; m_rem = 0; m_op = 0;
      for (int c = 0; c < 400; c++) begin
         reset      = (c == 0) || ($urandom_range(0, 59) == 0);
         enable     = ($urandom_range(0, 7) != 0);
         cmd_valid  = $urandom_range(0, 1) == 1;
         cmd_op     = 3'($urandom_range(0, 7));
         cmd_amount = 4'($urandom_range(0, 11));
         datain     = 8'($urandom);
         serial_in  = $urandom_range(0, 1) == 1;
         if (reset) begin
            m_d = 8'h00; m_so = 1'b0; m_done = 1'b0; m_rem = 0;
         end else if (enable) begin
            m_done = 1'b0;
            if (m_rem == 0) begin
               if (cmd_valid) begin
                  if (cmd_op == 3'd0) begin
                     m_d = datain;
                     m_done = 1'b1;
                  end else if (multi_op(int'(cmd_op)) && cmd_amount != 0) begin
                     mstep(int'(cmd_op), serial_in, m_d, m_so);
                     m_op  = int'(cmd_op);
                     m_rem = int'(cmd_amount) - 1;
                     m_done = (m_rem == 0);
                  end else begin
                     m_done = 1'b1;
                  end
               end
            end else begin
               mstep(m_op, serial_in, m_d, m_so);
               m_rem--;
               m_done = (m_rem == 0);
            end
         end
         tick();
         chk($sformatf("rnd%0d_data", c), dataout, m_d);
         chk($sformatf("rnd%0d_sout", c), serial_out, m_so);
         chk($sformatf("rnd%0d_done", c), done, m_done);
         chk($sformatf("rnd%0d_busy", c), busy, m_rem > 0);
         chk($sformatf("rnd%0d_ready", c), cmd_ready, m_rem == 0);
      end
      reset = 1'b0;
      cmd_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
